mult_iter: RTL and testbench
============================

MULT_ITER -- requirements
Module: mult_iter

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits; legal values are 8..64.
REQ-002 Parameter BITS_PER_CYCLE, default 1: multiplier bits retired per iteration; must be 1, 2 or 4 and must divide WIDTH.
REQ-003 Clock  in  1  single clock; all state updates on its rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 Start  in  1  request a new operation; accepted only when Busy=0.
REQ-006 Signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with Start.
REQ-007 Acc  in  1  1 = add the product to the current Out (multiply-accumulate), 0 = overwrite Out; sampled with Start.
REQ-008 Abort  in  1  cancel an operation in flight.
REQ-009 A, B  in  WIDTH  operands; sampled with Start.
REQ-010 Busy  out  1  operation in progress.
REQ-011 Done  out  1  single-cycle pulse, high in the first cycle Out holds a new result.
REQ-012 Out  out  2*WIDTH  registered result, held between operations.

Function
REQ-013 Let N = WIDTH/BITS_PER_CYCLE; the FSM states are IDLE, CALC and FINISH.
REQ-014 IDLE: Busy=0; if Start=1 at edge k, capture A, B, Signed and Acc, then enter CALC with Busy=1 from cycle k+1.
REQ-015 CALC: runs exactly N cycles, shift-add over unsigned operand magnitudes, BITS_PER_CYCLE multiplier bits per cycle, then enters FINISH.
REQ-016 Signed mode: each magnitude = |operand|; magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), held in WIDTH unsigned bits with no overflow.
REQ-017 FINISH: one cycle; two's-complement negate the magnitude product when Signed=1 and the operand signs differ.
REQ-018 FINISH: Out <= Acc ? Out + product : product, truncated modulo 2^(2*WIDTH); state returns to IDLE.
REQ-019 Done=1 and Busy=0 in cycle k+N+2 (latency N+2 from the Start edge); Done=0 in all other cycles.
REQ-020 Start while Busy=1 is ignored with no queuing; Start in the Done cycle is accepted.
REQ-021 A, B, Signed and Acc changes after the capture edge have no effect on the operation in flight.
REQ-022 Abort=1 while Busy=1: return to IDLE at the next edge; Out unchanged; no Done.
REQ-023 Abort while Busy=0 has no effect; Abort and Start together while Busy=0: Start takes effect.
REQ-024 Out changes only in FINISH or on reset.

Reset
REQ-025 Reset=1 at an edge: state=IDLE, Busy=0, Done=0, Out=0, internal accumulators=0, regardless of state.
REQ-026 Reset overrides Start and Abort; an operation interrupted by reset produces no Done and no Out update.

Structure
REQ-027 Package mult_pkg holds the FSM state enum (IDLE, CALC, FINISH) and the legal BITS_PER_CYCLE range check.
REQ-028 Sub-module mult_step: combinational single iteration (partial-product add plus shift, BITS_PER_CYCLE wide); instantiated once.
REQ-029 Elaboration fails on an illegal WIDTH or BITS_PER_CYCLE.
REQ-030 Estimated size is 150-300 RTL lines in total.

Verification (WIDTH=32, BITS_PER_CYCLE=1 unless stated; Done at cycle k+34)
REQ-031 Unsigned 3*5, then 0xFFFFFFFF*0xFFFFFFFF -> Out=0x000000000000000F, then 0xFFFFFFFE00000001; Busy high exactly 33 cycles each.
REQ-032 Signed -1*-1 -> 0x0000000000000001; signed -1*1 -> 0xFFFFFFFFFFFFFFFF; signed 0x80000000*0x80000000 -> 0x4000000000000000.
REQ-033 Accumulate: unsigned 3*5 (Acc=0), then 2*3 with Acc=1 -> Out=0x15; then signed -1*7 with Acc=1 -> Out=0x0E.
REQ-034 Start pulsed again at cycles k+5 and k+20 with different operands -> ignored, first result only, one Done pulse; Start in the Done cycle -> accepted.
REQ-035 Abort at cycle k+10 -> Busy=0 at k+11, Out keeps its previous value, no Done; Reset at k+10 -> Out=0, Busy=0, no Done.
REQ-036 BITS_PER_CYCLE=4, WIDTH=16: signed 0x8000*0x7FFF -> Out=0xC0008000 with Done at k+6.

Source files
------------

// File: rtl/mult_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : mult_pkg
// Brief    : Shared FSM encoding and parameter legality helpers for mult_iter.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int c_MIN_WIDTH = 8;
  localparam int c_MAX_WIDTH = 64;

  function automatic bit width_legal(input int width);
    return (width >= c_MIN_WIDTH) && (width <= c_MAX_WIDTH);
  endfunction

  function automatic bit bpc_legal(input int width, input int bpc);
    return ((bpc == 1) || (bpc == 2) || (bpc == 4)) && ((width % bpc) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_step.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : mult_step
// Brief    : One shift-add iteration; retires BPC multiplier bits from the low
//            end of the product register.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module mult_step
  import mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic [2*WIDTH-1:0] i_prod,
  input  logic [WIDTH-1:0]   i_mcand,
  output logic [2*WIDTH-1:0] o_prod
);

  logic [WIDTH+BPC-1:0]   w_pp;
  logic [WIDTH+BPC-1:0]   w_upper;
  logic [2*WIDTH+BPC-1:0] w_wide;

  // Upper half plus partial product never exceeds WIDTH+BPC bits.
  always_comb begin
    w_pp = '0;
    for (int i = 0; i < BPC; i++) begin
      if (i_prod[i]) begin
        w_pp = w_pp + ({{BPC{1'b0}}, i_mcand} << i);
      end
    end
    w_upper = {{BPC{1'b0}}, i_prod[2*WIDTH-1:WIDTH]} + w_pp;
    w_wide  = {w_upper, i_prod[WIDTH-1:0]};
    o_prod  = w_wide[2*WIDTH+BPC-1:BPC];
  end

endmodule
`default_nettype wire

// File: rtl/mult_iter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : mult_iter
// Brief    : Iterative signed/unsigned multiplier with optional accumulate.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module mult_iter
  import mult_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_signed,
  input  logic               i_acc,
  input  logic               i_abort,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_out
);

  localparam int c_N  = WIDTH / BITS_PER_CYCLE;
  localparam int c_CW = $clog2(c_N + 1);

  generate
    if (!width_legal(WIDTH) || !bpc_legal(WIDTH, BITS_PER_CYCLE)) begin : g_bad_param
      $error("mult_iter: illegal WIDTH/BITS_PER_CYCLE combination");
    end
  endgenerate

  state_t             r_state;
  state_t             w_next;
  logic [c_CW-1:0]    r_cnt;
  logic [2*WIDTH-1:0] r_prod;
  logic [2*WIDTH-1:0] r_out;
  logic [2*WIDTH-1:0] w_step;
  logic [2*WIDTH-1:0] w_final;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               r_neg;
  logic               r_acc;
  logic               r_done;
  logic               w_last;

  // -2^(WIDTH-1) negates to itself, which read unsigned is the right magnitude.
  assign w_mag_a = (i_signed && i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_mag_b = (i_signed && i_b[WIDTH-1]) ? -i_b : i_b;
  assign w_final = r_neg ? -r_prod : r_prod;
  assign w_last  = (r_cnt == c_CW'(c_N - 1));

  mult_step #(
    .WIDTH (WIDTH),
    .BPC   (BITS_PER_CYCLE)
  ) u_step (
    .i_prod  (r_prod),
    .i_mcand (r_mcand),
    .o_prod  (w_step)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = CALC;
      CALC:    if (i_abort) w_next = IDLE;
               else if (w_last) w_next = FINISH;
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_prod  <= '0;
      r_out   <= '0;
      r_mcand <= '0;
      r_neg   <= 1'b0;
      r_acc   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_prod  <= {{WIDTH{1'b0}}, w_mag_b};
            r_mcand <= w_mag_a;
            r_neg   <= i_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_acc   <= i_acc;
            r_cnt   <= '0;
          end
        end
        CALC: begin
          if (!i_abort) begin
            r_prod <= w_step;
            r_cnt  <= r_cnt + 1'b1;
          end
        end
        FINISH: begin
          if (!i_abort) begin
            r_out  <= r_acc ? (r_out + w_final) : w_final;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (r_state != IDLE);
  assign o_done = r_done;
  assign o_out  = r_out;

endmodule
`default_nettype wire

// File: tb/tb_mult_iter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_mult_iter
// Brief    : Directed self-checking bench for mult_iter (32x1 and 16x4 builds).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_mult_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, sgn, acc, abort;
  logic [31:0] a, b;
  logic        busy, done;
  logic [63:0] out;

  logic        s_start, s_sgn, s_acc, s_abort;
  logic [15:0] s_a, s_b;
  logic        s_busy, s_done;
  logic [31:0] s_out;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  mult_iter #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut32 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_signed(sgn), .i_acc(acc),
    .i_abort(abort), .i_a(a), .i_b(b), .o_busy(busy), .o_done(done), .o_out(out)
  );

  mult_iter #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_dut16 (
    .i_clk(clk), .i_rst(rst), .i_start(s_start), .i_signed(s_sgn), .i_acc(s_acc),
    .i_abort(s_abort), .i_a(s_a), .i_b(s_b), .o_busy(s_busy), .o_done(s_done), .o_out(s_out)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns in the Done cycle so the next call starts exactly there.
  task automatic run_op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                        input logic vs, input logic vacc, input logic [63:0] exp,
                        input bit ign, input bit with_abort);
    int lat;
    int nbusy;
    a = va; b = vb; sgn = vs; acc = vacc;
    start = 1'b1; abort = with_abort;
    tick();
    start = 1'b0; abort = 1'b0;
    lat = 0; nbusy = 0;
    for (int c = 1; c <= 80; c++) begin
      if (done) begin
        lat = c;
        break;
      end
      if (busy) nbusy++;
      a = ~va; b = va ^ 32'h5A5A_5A5A; sgn = ~vs; acc = ~vacc;
      start = ign && (c == 5 || c == 20);
      tick();
    end
    start = 1'b0;
    check({tag, "_lat"}, 64'(lat), 64'd34);
    check({tag, "_busy"}, 64'(nbusy), 64'd33);
    check({tag, "_out"}, out, exp);
  endtask

  task automatic run16(input string tag, input logic [15:0] va, input logic [15:0] vb,
                       input logic vs, input logic [31:0] exp);
    int lat;
    s_a = va; s_b = vb; s_sgn = vs; s_acc = 1'b0;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      if (s_done) begin
        lat = c;
        break;
      end
      tick();
    end
    check({tag, "_lat"}, 64'(lat), 64'd6);
    check({tag, "_out"}, 64'(s_out), 64'(exp));
  endtask

  initial begin
    int ndone;
    rst = 1'b1;
    start = 1'b0; sgn = 1'b0; acc = 1'b0; abort = 1'b0; a = '0; b = '0;
    s_start = 1'b0; s_sgn = 1'b0; s_acc = 1'b0; s_abort = 1'b0; s_a = '0; s_b = '0;
    repeat (3) tick();
    check("rst_out", out, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_out16", 64'(s_out), 64'd0);
    rst = 1'b0;
    tick();

    run_op("u3x5", 32'd3, 32'd5, 1'b0, 1'b0, 64'h0000_0000_0000_000F, 1'b0, 1'b0);
    run_op("umax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b0);
    run_op("sm1m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'h0000_0000_0000_0001, 1'b0, 1'b1);
    run_op("sm1p1", 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    run_op("smin", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 64'h4000_0000_0000_0000, 1'b0, 1'b0);
    run_op("ign", 32'd3, 32'd5, 1'b0, 1'b0, 64'h0000_0000_0000_000F, 1'b1, 1'b0);
    run_op("acc1", 32'd2, 32'd3, 1'b0, 1'b1, 64'h0000_0000_0000_0015, 1'b0, 1'b0);
    run_op("acc2", 32'hFFFF_FFFF, 32'd7, 1'b1, 1'b1, 64'h0000_0000_0000_000E, 1'b0, 1'b0);

    // Abort at k+10: no result, no Done.
    a = 32'd7; b = 32'd7; sgn = 1'b0; acc = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_out", out, 64'h0000_0000_0000_000E);
    ndone = 0;
    repeat (40) begin
      if (done) ndone++;
      tick();
    end
    check("abort_nodone", 64'(ndone), 64'd0);
    check("abort_hold", out, 64'h0000_0000_0000_000E);

    run_op("post_abort", 32'd4, 32'd4, 1'b0, 1'b1, 64'h0000_0000_0000_001E, 1'b0, 1'b0);

    // Reset at k+10: Out cleared, no Done afterwards.
    a = 32'd7; b = 32'd7; sgn = 1'b0; acc = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst10_busy", 64'(busy), 64'd0);
    check("rst10_out", out, 64'd0);
    ndone = 0;
    repeat (40) begin
      if (done) ndone++;
      tick();
    end
    check("rst10_nodone", 64'(ndone), 64'd0);

    run16("w16_smin", 16'h8000, 16'h7FFF, 1'b1, 32'hC000_8000);
    run16("w16_umax", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
    tick();
    check("w16_pulse", 64'(s_done), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
